// File: rtl/keypad4x4_scan.sv
// keypad4x4_scan: scans a 4x4 key matrix with active-low row strobes,
// debounces whole-matrix snapshots and queues each newly pressed key as a
// 4-bit code (row*4+col) in a small first-word-fall-through FIFO.
module keypad4x4_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    parameter int FIFO_AW  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_rd,
    output logic [15:0] key_map,
    output logic        pressed,
    output logic        overflow
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // Column synchroniser
    logic [3:0]       col_s1_q, col_s2_q;

    // Scan state
    logic [DIV_W-1:0] div_q;
    logic [1:0]       row_q;
    logic [3:0]       row_n_q;
    logic [15:0]      raw_q, raw_d;
    logic [15:0]      prev_q;
    logic [3:0]       stable_q, stable_d;
    logic             upd_q;

    // Debounced state and event generation
    logic [15:0]      map_q;
    logic             pressed_q;
    logic [15:0]      pending_q, pending_d;
    logic [15:0]      push_mask;
    logic [3:0]       push_code;
    logic             push_req;

    // Event FIFO
    logic [3:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
    logic             fifo_empty, fifo_full;
    logic             do_pop, do_push, do_drop;
    logic             ovf_q;

    logic             row_end, scan_end, debounce_hit;
    logic [1:0]       row_next;

    assign row_end  = (div_q == DIV_LAST);
    assign scan_end = row_end && (row_q == 2'd3);
    assign row_next = row_q + 2'd1;

    // Snapshot with the current row's columns merged in, and the stability count it implies
    always_comb begin
        raw_d = raw_q;
        raw_d[{row_q, 2'b00} +: 4] = ~col_s2_q;
        if (raw_d == prev_q) begin
            stable_d = (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;
        end else begin
            stable_d = 4'd0;
        end
        debounce_hit = ({1'b0, stable_d} + 5'd1) >= 5'(DEBOUNCE);
    end

    // Two-flop synchroniser for the asynchronous column lines (idle = released)
    always_ff @(posedge clk) begin
        if (reset) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
        end else begin
            col_s1_q <= col_n;
            col_s2_q <= col_s1_q;
        end
    end

    // Row divider, row strobe rotation and snapshot capture at the end of each row
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            row_q    <= 2'd0;
            row_n_q  <= 4'b1110;
            raw_q    <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            upd_q    <= 1'b0;
        end else begin
            upd_q <= scan_end && debounce_hit;
            if (row_end) begin
                div_q   <= '0;
                row_q   <= row_next;
                row_n_q <= ~(4'b0001 << row_next);
                raw_q   <= raw_d;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (scan_end) begin
                prev_q   <= raw_d;
                stable_q <= stable_d;
            end
        end
    end

    // Lowest pending key wins so simultaneous presses enqueue in ascending code order
    always_comb begin
        push_mask = '0;
        push_code = '0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_q[i]) begin
                push_mask = 16'(1) << i;
                push_code = 4'(i);
            end
        end
        push_req  = |pending_q;
        pending_d = (pending_q & ~push_mask) | (upd_q ? (prev_q & ~map_q) : 16'h0000);
    end

    // Debounced map update; only newly set bits become events, releases are silent
    always_ff @(posedge clk) begin
        if (reset) begin
            map_q     <= '0;
            pressed_q <= 1'b0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (upd_q) begin
                map_q     <= prev_q;
                pressed_q <= |prev_q;
            end
        end
    end

    // Key port handshake: key_valid=1 means key_code holds the oldest event;
    // key_rd sampled high while key_valid=1 consumes it on that clock edge,
    // key_rd while key_valid=0 has no effect. A pop frees a slot for a push
    // in the same cycle, so a full FIFO only drops when nobody is reading.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign do_pop     = key_rd && !fifo_empty;
    assign do_push    = push_req && (!fifo_full || do_pop);
    assign do_drop    = push_req && fifo_full && !do_pop;

    // Event FIFO storage, pointers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_code;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign row_n     = row_n_q;
    assign key_code  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign key_valid = !fifo_empty;
    assign key_map   = map_q;
    assign pressed   = pressed_q;
    assign overflow  = ovf_q;

endmodule
